cnn_layer_sequencer: RTL and testbench
======================================

// Module: cnn_layer_sequencer
// PURPOSE
// - Frame-level scheduler for the CNN inference pipeline (conv -> relu -> pool -> flatten -> dense).
// - Launches each layer with a 1-cycle start pulse, waits for its done pulse, then launches the next layer.
// - Reports frame completion, counts completed frames and detects hung layers.
// - Sits between the top-level frame controller and the per-layer start/done handshakes.
// PARAMETERS
// - N_STAGES        5     number of layers sequenced; stage 0 launches first; range 1..8
// - TIMEOUT_CYCLES  4096  watchdog limit per stage, in clk cycles (WATCHDOG_EN only); >= 2
// - FCNT_W          16    width of the completed-frame counter
// PORTS
// - clk          in   1         clock
// - rst_n        in   1         asynchronous, active-low reset
// - frame_start  in   1         request a new frame; sampled in IDLE or ERR only
// - abort        in   1         cancel the current frame; highest priority
// - stage_done   in   N_STAGES  per-layer done pulses, from the layers
// - stage_start  out  N_STAGES  one-hot 1-cycle start pulses, to the layers
// - cur_stage    out  3         index of the active or last-launched stage
// - busy         out  1         high while in RUN
// - frame_done   out  1         1-cycle pulse after the last stage completes
// - err_timeout  out  1         sticky watchdog error flag
// - frame_cnt    out  FCNT_W    number of completed frames; wraps
// BEHAVIOUR
// - Reset values: state=IDLE, stage_start=0, cur_stage=0, busy=0, frame_done=0, err_timeout=0, frame_cnt=0.
// - All outputs are registered. States: IDLE, RUN, ERR.
// - IDLE, frame_start=1 -> RUN. Next cycle: stage_start[0]=1, cur_stage=0, busy=1.
// - RUN: only stage_done[cur_stage] is honoured. Done bits from any other stage are ignored.
// - RUN, done on stage i < N_STAGES-1 at cycle k:
//   - cycle k+1: stage_start[i+1]=1 and cur_stage=i+1.
//   - No idle gap between stages.
// - RUN, done on stage N_STAGES-1 at cycle k:
//   - cycle k+1: frame_done=1, busy=0, state=IDLE.
//   - frame_cnt increments in the same cycle and wraps from 2^FCNT_W-1 to 0.
//   - cur_stage holds N_STAGES-1.
// - Done sampling:
//   - stage_done is not sampled in the same cycle that stage_start is high.
//   - A done pulse coincident with its own start pulse is ignored.
// - frame_start while in RUN is ignored; it is not queued.
// - abort (any state, any cycle):
//   - Next cycle: state=IDLE, stage_start=0, busy=0, err_timeout=0.
//   - No frame_done and no frame_cnt change.
//   - abort wins over a coincident stage_done or frame_start.
// - N_STAGES=1: the frame consists of stage 0 only; the same rules apply.
// - Reset asserted mid-frame returns all outputs to reset values immediately (asynchronous).
// CONFIGURATION
// - WATCHDOG_EN defined:
//   - A per-stage cycle counter clears on every stage_start pulse and increments in RUN.
//   - If the counter reaches TIMEOUT_CYCLES without the awaited done: next cycle state=ERR, busy=0, err_timeout=1.
//   - No start pulse is issued in that cycle.
//   - ERR holds err_timeout=1.
//   - frame_start in ERR clears err_timeout and launches stage 0 exactly as from IDLE.
//   - abort in ERR -> IDLE with err_timeout=0.
// - WATCHDOG_EN undefined:
//   - No counter and no ERR state; RUN waits indefinitely.
//   - err_timeout is tied to 0.
// TESTING
// - N_STAGES=5, done delays 3/1/10/121/7 cycles:
//   - One start pulse per stage, each 1 cycle after the previous done.
//   - frame_done 1 cycle after stage 4 done; frame_cnt=1.
// - In RUN on stage 2:
//   - Pulse stage_done[0] and stage_done[4] -> no advance, cur_stage stays 2.
//   - Then stage_done[2] -> stage_start[3] next cycle.
// - frame_start pulsed during stage 1 -> ignored; exactly one frame_done, frame_cnt increments by 1 only.
// - abort coincident with stage_done[3]:
//   - IDLE next cycle, no stage_start[4], no frame_done, frame_cnt unchanged.
//   - A new frame_start then restarts at stage 0.
// - WATCHDOG_EN, TIMEOUT_CYCLES=16, stage 1 never done:
//   - err_timeout=1 and busy=0, 17 cycles after stage_start[1].
//   - A following frame_start clears err_timeout and pulses stage_start[0].
// - FCNT_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.
// - Assert rst_n low mid-stage -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the frame controller / CNN layers and the
// layer sequencer. The master modport belongs to whoever drives the frame
// requests and the per-layer done pulses. The slave modport belongs to
// the sequencer itself.
interface cnn_layer_sequencer_if #(
    parameter int N_STAGES = 5,
    parameter int FCNT_W   = 16
);
    logic                frame_start;
    logic                abort;
    logic [N_STAGES-1:0] stage_done;
    logic [N_STAGES-1:0] stage_start;
    logic [2:0]          cur_stage;
    logic                busy;
    logic                frame_done;
    logic                err_timeout;
    logic [FCNT_W-1:0]   frame_cnt;

    modport master (
        output frame_start, abort, stage_done,
        input  stage_start, cur_stage, busy, frame_done, err_timeout, frame_cnt
    );

    modport slave (
        input  frame_start, abort, stage_done,
        output stage_start, cur_stage, busy, frame_done, err_timeout, frame_cnt
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Frame-level scheduler for the CNN pipeline (conv -> relu -> pool -> flatten -> dense).
// The sequencer launches each layer with a one-cycle start pulse and waits for
// that layer's done pulse before it launches the next layer. It reports frame
// completion and counts completed frames.
// Optional feature macro: WATCHDOG_EN adds a per-stage hang detector and an
// ERR state. When the macro is undefined, RUN waits indefinitely and
// err_timeout is tied low.
module cnn_layer_sequencer #(
    parameter int N_STAGES       = 5,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FCNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_layer_sequencer_if.slave  bus
);

    // Catch unsupported configurations at elaboration time.
    if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
        $error("cnn_layer_sequencer: N_STAGES must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cnn_layer_sequencer: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN
`ifdef WATCHDOG_EN
        , S_ERR
`endif
    } state_t;

    state_t              state_reg;
    logic [N_STAGES-1:0] stage_start_reg;
    logic [2:0]          cur_stage_reg;
    logic                busy_reg;
    logic                frame_done_reg;
    logic [FCNT_W-1:0]   frame_cnt_reg;
    logic [N_STAGES-1:0] cur_onehot;
    logic                done_hit;
    logic                launch_pending;
    logic                is_last;

    // This is a one-hot decode of the active stage. It selects the only done bit that is honoured.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_dec
        assign cur_onehot[gi] = (cur_stage_reg == 3'(gi));
    end

    // A done pulse that coincides with its own start pulse is not sampled.
    assign launch_pending = |stage_start_reg;
    assign done_hit       = |(bus.stage_done & cur_onehot);
    assign is_last        = (cur_stage_reg == 3'(N_STAGES - 1));

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_reg;
    logic            err_timeout_reg;
`endif

    // The sequencer FSM: it owns all registered outputs, the frame counter and the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            stage_start_reg <= '0;
            cur_stage_reg   <= 3'd0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_cnt_reg   <= '0;
`ifdef WATCHDOG_EN
            wdog_reg        <= '0;
            err_timeout_reg <= 1'b0;
`endif
        end else begin
            // Start and done outputs are pulses by default.
            stage_start_reg <= '0;
            frame_done_reg  <= 1'b0;
            if (bus.abort) begin
                state_reg       <= S_IDLE;
                busy_reg        <= 1'b0;
`ifdef WATCHDOG_EN
                err_timeout_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (bus.frame_start) begin
                            state_reg       <= S_RUN;
                            stage_start_reg <= N_STAGES'(1);
                            cur_stage_reg   <= 3'd0;
                            busy_reg        <= 1'b1;
`ifdef WATCHDOG_EN
                            wdog_reg        <= '0;
`endif
                        end
                    end
                    S_RUN: begin
                        if (!launch_pending && done_hit) begin
                            if (is_last) begin
                                state_reg      <= S_IDLE;
                                busy_reg       <= 1'b0;
                                frame_done_reg <= 1'b1;
                                frame_cnt_reg  <= frame_cnt_reg + FCNT_W'(1);
                            end else begin
                                stage_start_reg <= cur_onehot << 1;
                                cur_stage_reg   <= cur_stage_reg + 3'd1;
`ifdef WATCHDOG_EN
                                wdog_reg        <= '0;
`endif
                            end
                        end
`ifdef WATCHDOG_EN
                        else if (wdog_reg == WD_W'(TIMEOUT_CYCLES)) begin
                            state_reg       <= S_ERR;
                            busy_reg        <= 1'b0;
                            err_timeout_reg <= 1'b1;
                        end else begin
                            wdog_reg <= wdog_reg + WD_W'(1);
                        end
`endif
                    end
`ifdef WATCHDOG_EN
                    S_ERR: begin
                        // A new frame request recovers from a hang, exactly as a launch from IDLE does.
                        if (bus.frame_start) begin
                            state_reg       <= S_RUN;
                            stage_start_reg <= N_STAGES'(1);
                            cur_stage_reg   <= 3'd0;
                            busy_reg        <= 1'b1;
                            err_timeout_reg <= 1'b0;
                            wdog_reg        <= '0;
                        end
                    end
`endif
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stage_start = stage_start_reg;
    assign bus.cur_stage   = cur_stage_reg;
    assign bus.busy        = busy_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
`ifdef WATCHDOG_EN
    assign bus.err_timeout = err_timeout_reg;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer. Instance A uses five stages and a
// 16-cycle watchdog limit. Instance B uses one stage and a 2-bit frame
// counter, to exercise counter wrap.
module tb_cnn_layer_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_count = 0;

    always #5 clk = ~clk;

    cnn_layer_sequencer_if #(.N_STAGES(5), .FCNT_W(16)) bus_a ();
    cnn_layer_sequencer_if #(.N_STAGES(1), .FCNT_W(2))  bus_b ();

    cnn_layer_sequencer #(.N_STAGES(5), .TIMEOUT_CYCLES(16), .FCNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    cnn_layer_sequencer #(.N_STAGES(1), .TIMEOUT_CYCLES(16), .FCNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Count frame_done pulses on A, to prove that each frame completes exactly once.
    always @(negedge clk) begin
        if (bus_a.frame_done === 1'b1) fd_count <= fd_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch_a();
        bus_a.frame_start = 1'b1;
        step();
        bus_a.frame_start = 1'b0;
        check("launch_start0", 32'(bus_a.stage_start), 32'h01);
        check("launch_cur0",   32'(bus_a.cur_stage),   32'd0);
        check("launch_busy",   32'(bus_a.busy),        32'd1);
    endtask

    // Entered in the cycle in which stage i's start pulse is visible. The task pulses done d cycles later.
    task automatic finish_stage(input int i, input int d, input logic [15:0] exp_cnt);
        for (int j = 0; j < d; j++) begin
            step();
            if (j == 0) check("start_one_cycle", 32'(bus_a.stage_start), 32'h0);
        end
        bus_a.stage_done = 5'(1 << i);
        step();
        bus_a.stage_done = '0;
        if (i < 4) begin
            check("next_start", 32'(bus_a.stage_start), 32'(1 << (i + 1)));
            check("next_cur",   32'(bus_a.cur_stage),   32'(i + 1));
        end else begin
            check("frame_done", 32'(bus_a.frame_done), 32'd1);
            check("done_busy",  32'(bus_a.busy),       32'd0);
            check("done_cur",   32'(bus_a.cur_stage),  32'd4);
            check("frame_cnt",  32'(bus_a.frame_cnt),  32'(exp_cnt));
        end
    endtask

    initial begin
        logic [1:0] exp_b [5];
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n = 1'b0;
        bus_a.frame_start = 1'b0; bus_a.abort = 1'b0; bus_a.stage_done = '0;
        bus_b.frame_start = 1'b0; bus_b.abort = 1'b0; bus_b.stage_done = '0;
        step(); step();
        check("rst_start", 32'(bus_a.stage_start), 32'h0);
        check("rst_cur",   32'(bus_a.cur_stage),   32'd0);
        check("rst_busy",  32'(bus_a.busy),        32'd0);
        check("rst_fdone", 32'(bus_a.frame_done),  32'd0);
        check("rst_err",   32'(bus_a.err_timeout), 32'd0);
        check("rst_cnt",   32'(bus_a.frame_cnt),   32'd0);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(bus_a.busy), 32'd0);

        // Frame 1 uses done delays of 3/1/10/121/7.
        launch_a();
        finish_stage(0, 3, 16'd0);
        finish_stage(1, 1, 16'd0);
        finish_stage(2, 10, 16'd0);
        finish_stage(3, 121, 16'd0);
        finish_stage(4, 7, 16'd1);
        step();
        check("fdone_pulse", 32'(bus_a.frame_done), 32'd0);

        // Frame 2 covers an ignored frame_start, ignored foreign done bits and a done that coincides with its start.
        launch_a();
        finish_stage(0, 3, 16'd1);
        step();
        bus_a.frame_start = 1'b1;
        step();
        bus_a.frame_start = 1'b0;
        check("fs_ign_start", 32'(bus_a.stage_start), 32'h0);
        check("fs_ign_cur",   32'(bus_a.cur_stage),   32'd1);
        check("fs_ign_busy",  32'(bus_a.busy),        32'd1);
        finish_stage(1, 2, 16'd1);
        step(); step();
        bus_a.stage_done = 5'b10001;
        step();
        bus_a.stage_done = '0;
        check("foreign_start", 32'(bus_a.stage_start), 32'h0);
        check("foreign_cur",   32'(bus_a.cur_stage),   32'd2);
        finish_stage(2, 1, 16'd1);
        bus_a.stage_done = 5'b01000;
        step();
        bus_a.stage_done = '0;
        check("coinc_start", 32'(bus_a.stage_start), 32'h0);
        check("coinc_cur",   32'(bus_a.cur_stage),   32'd3);
        finish_stage(3, 2, 16'd1);
        finish_stage(4, 2, 16'd2);
        step();
        check("one_fdone", 32'(fd_count), 32'd2);

        // Frame 3 is aborted in the same cycle that stage 3 reports done.
        launch_a();
        finish_stage(0, 1, 16'd2);
        finish_stage(1, 1, 16'd2);
        finish_stage(2, 1, 16'd2);
        step(); step();
        bus_a.stage_done = 5'b01000;
        bus_a.abort = 1'b1;
        step();
        bus_a.stage_done = '0;
        bus_a.abort = 1'b0;
        check("abort_busy",  32'(bus_a.busy),        32'd0);
        check("abort_start", 32'(bus_a.stage_start), 32'h0);
        check("abort_fdone", 32'(bus_a.frame_done),  32'd0);
        check("abort_cnt",   32'(bus_a.frame_cnt),   32'd2);
        step(); step();
        check("abort_nostart", 32'(bus_a.stage_start), 32'h0);
        check("abort_fdcount", 32'(fd_count),          32'd2);
        launch_a();
        finish_stage(0, 2, 16'd2);
        finish_stage(1, 2, 16'd2);
        finish_stage(2, 2, 16'd2);
        finish_stage(3, 2, 16'd2);
        finish_stage(4, 2, 16'd3);

        // Assert reset asynchronously in the middle of a stage, away from any clock edge.
        launch_a();
        finish_stage(0, 1, 16'd3);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_start", 32'(bus_a.stage_start), 32'h0);
        check("arst_cur",   32'(bus_a.cur_stage),   32'd0);
        check("arst_busy",  32'(bus_a.busy),        32'd0);
        check("arst_err",   32'(bus_a.err_timeout), 32'd0);
        check("arst_cnt",   32'(bus_a.frame_cnt),   32'd0);
        #2 rst_n = 1'b1;
        step();

`ifdef WATCHDOG_EN
        // Stage 1 never reports done. The timeout lands 17 cycles after its start pulse.
        launch_a();
        finish_stage(0, 1, 16'd0);
        repeat (16) step();
        check("wd_pre_err",  32'(bus_a.err_timeout), 32'd0);
        check("wd_pre_busy", 32'(bus_a.busy),        32'd1);
        step();
        check("wd_err",   32'(bus_a.err_timeout), 32'd1);
        check("wd_busy",  32'(bus_a.busy),        32'd0);
        check("wd_start", 32'(bus_a.stage_start), 32'h0);
        step(); step();
        check("wd_sticky", 32'(bus_a.err_timeout), 32'd1);
        bus_a.frame_start = 1'b1;
        step();
        bus_a.frame_start = 1'b0;
        check("wd_clr_err",   32'(bus_a.err_timeout), 32'd0);
        check("wd_rel_start", 32'(bus_a.stage_start), 32'h01);
        check("wd_rel_busy",  32'(bus_a.busy),        32'd1);
`else
        // Without the watchdog, a hung stage simply keeps the sequencer in RUN.
        launch_a();
        finish_stage(0, 1, 16'd0);
        repeat (30) step();
        check("nowd_err",  32'(bus_a.err_timeout), 32'd0);
        check("nowd_busy", 32'(bus_a.busy),        32'd1);
        check("nowd_cur",  32'(bus_a.cur_stage),   32'd1);
`endif
        bus_a.abort = 1'b1;
        step();
        bus_a.abort = 1'b0;
        check("final_abort_busy", 32'(bus_a.busy),        32'd0);
        check("final_abort_err",  32'(bus_a.err_timeout), 32'd0);

        // Instance B has a single stage and a 2-bit counter. It runs five frames, so the counter wraps.
        for (int k = 0; k < 5; k++) begin
            bus_b.frame_start = 1'b1;
            step();
            bus_b.frame_start = 1'b0;
            check("b_start", 32'(bus_b.stage_start), 32'h1);
            step();
            bus_b.stage_done = 1'b1;
            step();
            bus_b.stage_done = 1'b0;
            check("b_fdone", 32'(bus_b.frame_done), 32'd1);
            check("b_cnt",   32'(bus_b.frame_cnt),  32'(exp_b[k]));
            check("b_cur",   32'(bus_b.cur_stage),  32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
